// File: rtl/logic_pkg.sv
// Shared constants and helpers for the bitwise logic slice of the execute stage.
package logic_pkg;

  localparam int DEFAULT_WIDTH = 64;

  localparam logic OP_AND = 1'b0;
  localparam logic OP_OR  = 1'b1;

  // Number of 4-input levels needed to reduce n inputs to one; n must be a power of 4.
  function automatic int log4(input int n);
    int levels;
    int rem;
    levels = 0;
    rem    = n;
    while (rem > 1) begin
      rem    = rem / 4;
      levels = levels + 1;
    end
    return levels;
  endfunction

  // Result flags captured alongside the selected result.
  typedef struct packed {
    logic zero;
    logic all_ones;
    logic negative;
  } flags_t;

endpackage

// File: rtl/bitwise_logic_unit_and_reduce_tree.sv
// 4-ary AND reduction tree: WIDTH inputs collapse to one output over log4(WIDTH) levels.
module and_reduce_tree
  import logic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in_i,
  output logic             out_o
);

  localparam int LEVELS = log4(WIDTH);

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NODES = WIDTH >> (2 * (l + 1));
    logic [NODES-1:0] node_s;

    for (genvar n = 0; n < NODES; n++) begin : g_node
      if (l == 0) begin : g_leaf
        assign node_s[n] = &in_i[4*n +: 4];
      end else begin : g_inner
        assign node_s[n] = &g_lvl[l-1].node_s[4*n +: 4];
      end
    end
  end

  assign out_o = g_lvl[LEVELS-1].node_s[0];

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered 64-bit AND/OR slice with zero, all-ones and negative flags; one-cycle latency.
module bitwise_logic_unit
  import logic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             all_ones,
  output logic             negative,
  output logic             out_valid
);

  logic [WIDTH-1:0] and_s;
  logic [WIDTH-1:0] or_s;
  logic [WIDTH-1:0] sel_s;
  logic [WIDTH-1:0] sel_n_s;
  logic             zero_c_s;
  logic             ones_c_s;

  logic [WIDTH-1:0] result_d, result_q;
  flags_t           flags_d, flags_q;
  logic             valid_d, valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign and_s[i]   = A[i] & B[i];
    assign or_s[i]    = A[i] | B[i];
    assign sel_s[i]   = (op == OP_OR) ? or_s[i] : and_s[i];
    assign sel_n_s[i] = ~sel_s[i];
  end

  // Zero is an AND of the inverted result, so both flags share one tree shape.
  and_reduce_tree #(.WIDTH(WIDTH)) u_zero_tree (
    .in_i  (sel_n_s),
    .out_o (zero_c_s)
  );

  and_reduce_tree #(.WIDTH(WIDTH)) u_ones_tree (
    .in_i  (sel_s),
    .out_o (ones_c_s)
  );

  // Capture on valid input; otherwise hold result and flags and drop valid.
  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    valid_d  = 1'b0;
    if (in_valid) begin
      result_d         = sel_s;
      flags_d.zero     = zero_c_s;
      flags_d.all_ones = ones_c_s;
      flags_d.negative = sel_s[WIDTH-1];
      valid_d          = 1'b1;
    end else begin
      result_d = result_q;
      flags_d  = flags_q;
      valid_d  = 1'b0;
    end
  end

  // Output register stage; reset clears everything including zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= {WIDTH{1'b0}};
      flags_q  <= '{zero: 1'b0, all_ones: 1'b0, negative: 1'b0};
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end

  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign all_ones  = flags_q.all_ones;
  assign negative  = flags_q.negative;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed-vector bench for bitwise_logic_unit with hand-computed expectations.
module tb_bitwise_logic_unit;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [63:0] A;
  logic [63:0] B;
  logic        op;
  logic [63:0] result;
  logic        zero;
  logic        all_ones;
  logic        negative;
  logic        out_valid;

  int tests_run;
  int tests_failed;

  bitwise_logic_unit #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .op        (op),
    .result    (result),
    .zero      (zero),
    .all_ones  (all_ones),
    .negative  (negative),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [63:0] r, input logic z,
                           input logic o, input logic n, input logic v);
    check({tag, ".result"},    result,    r);
    check({tag, ".zero"},      {63'd0, zero},      {63'd0, z});
    check({tag, ".all_ones"},  {63'd0, all_ones},  {63'd0, o});
    check({tag, ".negative"},  {63'd0, negative},  {63'd0, n});
    check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, v});
  endtask

  // Present one op, let it be captured, and sample #1 after the edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic o);
    A = a; B = b; op = o; in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    A = 64'hxxxx_xxxx_xxxx_xxxx;
    B = 64'hxxxx_xxxx_xxxx_xxxx;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    in_valid = 1'b0; A = 64'd0; B = 64'd0; op = 1'b0;
    reset_n  = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_all("reset", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("reset_held", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset_n = 1'b1;

    issue(64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    check_all("and", 64'h0F0F_0000_0F0F_0000, 1'b0, 1'b0, 1'b0, 1'b1);

    issue(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    check_all("or", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b1);

    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
    check_all("zero_and", 64'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
    check_all("ones_or", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 64; i++) begin
      logic [63:0] onehot;
      onehot = 64'd1 << i;
      issue(onehot, 64'd0, 1'b1);
      check_all($sformatf("bit%0d", i), onehot, 1'b0, 1'b0, (i == 63), 1'b1);
    end

    // Single hole: all ones except one bit must clear all_ones in the OR path.
    issue(64'hFFFF_FFFF_FFEF_FFFF, 64'd0, 1'b1);
    check_all("hole", 64'hFFFF_FFFF_FFEF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);

    issue(64'h1234_5678_9ABC_DEF0, 64'hFF00_FF00_FF00_FF00, 1'b0);
    check_all("b2b_1", 64'h1200_5600_9A00_DE00, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1);
    check_all("b2b_2", 64'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(64'hC000_0000_0000_0003, 64'h0F00_0000_0000_0030, 1'b1);
    check_all("b2b_3", 64'hCF00_0000_0000_0033, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    check_all("hold_1", 64'hCF00_0000_0000_0033, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    check_all("hold_2", 64'hCF00_0000_0000_0033, 1'b0, 1'b0, 1'b1, 1'b0);

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check_all("pre_rst", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b1);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_all("mid_rst", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("mid_rst_held", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    issue(64'h0000_0000_0000_00F0, 64'h0000_0000_0000_00FF, 1'b0);
    check_all("post_rst", 64'h0000_0000_0000_00F0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_unit.md
Name: bitwise_logic_unit

Overview:
- Registered 64-bit bitwise logic slice for the pipelined processor's execute stage.
- Computes the bitwise AND or bitwise OR of two operands.
- Derives a zero flag, an all-ones flag and a negative flag from the selected result using a tree-structured 64-input AND reduction.
- One-cycle latency; sits alongside the adder datapath and feeds the EX/MEM boundary.

Parameters:
- WIDTH, 64, operand/result width. Must be a power of 4 (16, 64, 256), because the reduction tree uses 4-input nodes.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op are valid this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- op  input  1  0 = bitwise AND, 1 = bitwise OR. Matches ALU cntrl[0] for codes 3'b100 and 3'b101.
- result  output  WIDTH  registered selected result
- zero  output  1  registered; 1 when result is all zeros
- all_ones  output  1  registered; 1 when result is all ones
- negative  output  1  registered; equals result[WIDTH-1]
- out_valid  output  1  registered; result and flags are valid this cycle

Behaviour:
- Reset:
  - reset_n low asynchronously clears result to 0, and clears zero, all_ones, negative and out_valid to 0.
  - zero resets to 0 (not 1) because out_valid is 0.
  - Outputs stay cleared while reset_n is low.
- Combinational stage:
  - and_v = A & B; or_v = A | B.
  - sel = op ? or_v : and_v.
  - zero_c = AND-reduce(~sel); ones_c = AND-reduce(sel).
- Register stage, on a rising clk edge with reset_n high:
  - If in_valid = 1: result <= sel, zero <= zero_c, all_ones <= ones_c, negative <= sel[WIDTH-1], out_valid <= 1.
  - If in_valid = 0: out_valid <= 0, and result and all flags hold their previous values.
- Latency is exactly 1 cycle, with full throughput of one operation per cycle. There is no backpressure.
- zero and all_ones are mutually exclusive for WIDTH > 0.
- Reduction tree:
  - Level 1: WIDTH/4 four-input AND nodes.
  - Each further level: groups of 4 outputs from the previous level.
  - Single root output; log4(WIDTH) levels (3 for 64).
- Edge cases:
  - X on A or B propagates only when in_valid = 1.
  - reset_n deasserts synchronously to clk at the bench; the first valid capture happens on the first edge after deassertion.

Decomposition:
- Shared package logic_pkg:
  - Constants OP_AND = 1'b0 and OP_OR = 1'b1.
  - Localparam for the default width, 64.
- One sub-module, and_reduce_tree, with parameter WIDTH:
  - Generate-based 4-ary AND tree from WIDTH inputs to 1 output.
  - Instantiated twice: once for zero (on ~sel) and once for all_ones (on sel).
- Bitwise AND/OR are inline generate loops; they need no separate modules.

Test Plan:
- Reset mid-operation:
  - Drive valid ops, then pull reset_n low between edges.
  - Required: result = 0, all flags = 0, out_valid = 0 immediately, without waiting for clk.
- AND:
  - Stimulus: A = 64'hFFFF_0000_FFFF_0000, B = 64'h0F0F_0F0F_0F0F_0F0F, op = 0, in_valid = 1.
  - Required next cycle: result = 64'h0F0F_0000_0F0F_0000, zero = 0, all_ones = 0, negative = 0, out_valid = 1.
- OR:
  - Stimulus: A = 64'h8000_0000_0000_0000, B = 64'h7FFF_FFFF_FFFF_FFFF, op = 1.
  - Required next cycle: result = 64'hFFFF_FFFF_FFFF_FFFF, all_ones = 1, zero = 0, negative = 1.
- Zero flag:
  - Stimulus: A = 64'hAAAA_AAAA_AAAA_AAAA, B = 64'h5555_5555_5555_5555, op = 0.
  - Required: result = 0, zero = 1, all_ones = 0.
  - Same operands with op = 1: result = all ones, zero = 0, all_ones = 1.
- Single-bit sensitivity of the reduction tree:
  - Stimulus: for each i in 0..63, A = 1 << i, B = 0, op = 1.
  - Required: zero = 0 and all_ones = 0 every cycle; negative = 1 only for i = 63.
- Hold and back-to-back:
  - Stimulus: three consecutive valid ops, then in_valid = 0 for 2 cycles.
  - Required: three results appear in order on consecutive cycles; out_valid then drops to 0 while result and flags retain the third op's values.
